pointer_reg_unit: RTL

- Holds the architectural pointer registers eip, ebp and esp, and updates them from stack and control-flow ops.
- Sits directly upstream of the register-output selector, which muxes these three buses onto registor_output.
- Owns the multi-cycle CALL/RET sequencing and the stack memory handshake, so the selector stays purely combinational.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/stack_ptr_alu.sv | 21 ++
 rtl/pointer_reg_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: op codes, stack step and pointer-unit states.
// STACK_GUARD_EN enables the stack bound guard (GUARD_EN below).
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSH  = 4'd1;
    localparam logic [3:0] OP_POP   = 4'd2;
    localparam logic [3:0] OP_JMP   = 4'd3;
    localparam logic [3:0] OP_CALL  = 4'd4;
    localparam logic [3:0] OP_RET   = 4'd5;
    localparam logic [3:0] OP_ENTER = 4'd6;
    localparam logic [3:0] OP_LEAVE = 4'd7;

    localparam logic [31:0] STACK_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALL_JUMP,
        ST_RET_WAIT
    } pru_state_e;

`ifdef STACK_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

endpackage

// File: rtl/stack_ptr_alu.sv
// Combinational esp +/- 4 next values and full/empty bound compare.
// Bound flags are forced low unless STACK_GUARD_EN is defined.
import cpu_pkg::*;

module stack_ptr_alu #(
    parameter logic [31:0] STACK_TOP   = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
    input  logic [31:0] i_esp,
    output logic [31:0] o_esp_dec,
    output logic [31:0] o_esp_inc,
    output logic        o_full,
    output logic        o_empty
);

    assign o_esp_dec = i_esp - STACK_STEP;
    assign o_esp_inc = i_esp + STACK_STEP;
    assign o_full    = GUARD_EN && (i_esp == STACK_LIMIT);
    assign o_empty   = GUARD_EN && (i_esp == STACK_TOP);

endmodule

// File: rtl/pointer_reg_unit.sv
// eip/ebp/esp pointer registers with CALL/RET sequencing and stack port.
// STACK_GUARD_EN turns on bound checks and the sticky fault flag.
import cpu_pkg::*;

module pointer_reg_unit #(
    parameter logic [31:0] RESET_EIP   = 32'h0000_0000,
    parameter logic [31:0] STACK_TOP   = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_code,
    input  logic [31:0] imm,
    input  logic        step,
    input  logic [3:0]  step_len,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] eip,
    output logic [31:0] ebp,
    output logic [31:0] esp,
    output logic        fault
);

    pru_state_e  r_state, w_state;
    logic [31:0] r_eip, r_ebp, r_esp, r_target;
    logic [31:0] w_eip, w_ebp, w_esp, w_target;
    logic [31:0] r_addr, r_wdata, w_addr, w_wdata;
    logic        r_wr, r_rd, r_fault;
    logic        w_wr, w_rd, w_fault;
    logic [31:0] w_esp_dec, w_esp_inc;
    logic        w_full, w_empty, w_accept;

    stack_ptr_alu #(
        .STACK_TOP   (STACK_TOP),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_alu (
        .i_esp     (r_esp),
        .o_esp_dec (w_esp_dec),
        .o_esp_inc (w_esp_inc),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_accept = op_valid && (r_state == ST_IDLE);

    always_comb begin
        w_state  = r_state;
        w_eip    = r_eip;
        w_ebp    = r_ebp;
        w_esp    = r_esp;
        w_target = r_target;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_wr     = 1'b0;
        w_rd     = r_rd;
        w_fault  = r_fault;
        unique case (r_state)
            ST_IDLE: begin
                if (step)
                    w_eip = r_eip + {28'd0, step_len};
                if (w_accept) begin
                    case (op_code)
                        OP_PUSH: begin
                            if (w_full) begin
                                w_fault = 1'b1;
                            end else begin
                                w_esp   = w_esp_dec;
                                w_wr    = 1'b1;
                                w_addr  = w_esp_dec;
                                w_wdata = imm;
                            end
                        end
                        OP_POP: begin
                            if (w_empty) begin
                                w_fault = 1'b1;
                            end else begin
                                w_esp  = w_esp_inc;
                                w_addr = r_esp;
                            end
                        end
                        OP_JMP: w_eip = imm;
                        OP_CALL: begin
                            // CALL owns eip this cycle even when blocked
                            w_eip = r_eip;
                            if (w_full) begin
                                w_fault = 1'b1;
                            end else begin
                                w_esp    = w_esp_dec;
                                w_wr     = 1'b1;
                                w_addr   = w_esp_dec;
                                w_wdata  = r_eip;
                                w_target = imm;
                                w_state  = ST_CALL_JUMP;
                            end
                        end
                        OP_RET: begin
                            if (w_empty) begin
                                w_fault = 1'b1;
                            end else begin
                                w_rd    = 1'b1;
                                w_addr  = r_esp;
                                w_state = ST_RET_WAIT;
                            end
                        end
                        OP_ENTER: w_ebp = r_esp;
                        OP_LEAVE: w_esp = r_ebp;
                        default: ;
                    endcase
                end
            end
            ST_CALL_JUMP: begin
                w_eip   = r_target;
                w_state = ST_IDLE;
            end
            ST_RET_WAIT: begin
                if (mem_rvalid) begin
                    w_eip   = mem_rdata;
                    w_esp   = w_esp_inc;
                    w_rd    = 1'b0;
                    w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_eip    <= RESET_EIP;
            r_ebp    <= STACK_TOP;
            r_esp    <= STACK_TOP;
            r_target <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_eip    <= w_eip;
            r_ebp    <= w_ebp;
            r_esp    <= w_esp;
            r_target <= w_target;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_wr     <= w_wr;
            r_rd     <= w_rd;
            r_fault  <= w_fault;
        end
    end

    assign op_ready  = (r_state == ST_IDLE);
    assign mem_wr    = r_wr;
    assign mem_rd    = r_rd;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign eip       = r_eip;
    assign ebp       = r_ebp;
    assign esp       = r_esp;
    assign fault     = r_fault;

endmodule
